// File: rtl/nts_keystore_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : nts_keystore_pkg                                             |
// | Purpose   : Shared types and constants for the NTS cookie master-key     |
// |             store: FSM state encoding, key geometry, length encodings.   |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package nts_keystore_pkg;

   localparam int KEY_WORDS = 16;   // 32-bit words per key slot (512 bits)
   localparam int WORD_W    = 32;

   localparam logic KEYLEN_256 = 1'b0;
   localparam logic KEYLEN_512 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } ks_state_t;

endpackage
`default_nettype wire

// File: rtl/nts_keystore_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : nts_keystore_mem                                             |
// | Purpose   : Key RAM, NUM_KEYS*16 words of 32 bits. One synchronous write |
// |             port, one asynchronous read port. Address = {slot, word}.    |
// | Ports     : i_clk                 clock                                  |
// |             i_we/i_waddr/i_wdata  write port                             |
// |             i_raddr/o_rdata       asynchronous read port                 |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module nts_keystore_mem
   import nts_keystore_pkg::*;
#(
   parameter int NUM_KEYS = 4,
   parameter int SLOT_W   = 2
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [SLOT_W+3:0] i_waddr,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic [SLOT_W+3:0] i_raddr,
   output logic [WORD_W-1:0] o_rdata
);

   // Key material is never reset; valid flags in the top level gate its use.
   logic [WORD_W-1:0] key_ram [NUM_KEYS*KEY_WORDS];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         key_ram[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = key_ram[i_raddr];

endmodule
`default_nettype wire

// File: rtl/nts_cookie_keystore.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : nts_cookie_keystore                                          |
// | Purpose   : Multi-slot master-key store for the NTS cookie path. Looks   |
// |             up a slot by key ID (or uses the current slot) and streams   |
// |             its 16 key words, 15 down to 0, to the cookie handler.       |
// | Ports     : i_wr_*        key/ID/valid/current-pointer write interface   |
// |             o_wr_error    pulse on a rejected write (busy / bad slot)    |
// |             i_lookup_*    lookup by key ID; i_current_start streams the  |
// |                           current slot                                   |
// |             o_busy/o_done/o_hit/o_slot   operation status and result     |
// |             o_current_*   key ID / valid of the current slot             |
// |             o_key_*       key word stream to nts_cookie_handler          |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module nts_cookie_keystore
   import nts_keystore_pkg::*;
#(
   parameter int NUM_KEYS = 4,
   parameter int SLOT_W   = 2
) (
   input  logic              i_clk,
   input  logic              i_areset,
   input  logic [SLOT_W-1:0] i_wr_slot,
   input  logic [3:0]        i_wr_word,
   input  logic [31:0]       i_wr_data,
   input  logic              i_wr_key_we,
   input  logic              i_wr_keyid_we,
   input  logic              i_wr_length,
   input  logic              i_wr_valid_set,
   input  logic              i_wr_valid_clr,
   input  logic              i_cur_we,
   output logic              o_wr_error,
   input  logic              i_lookup_start,
   input  logic [31:0]       i_lookup_keyid,
   input  logic              i_current_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_hit,
   output logic [SLOT_W-1:0] o_slot,
   output logic [31:0]       o_current_keyid,
   output logic              o_current_valid,
   output logic [3:0]        o_key_word,
   output logic              o_key_valid,
   output logic              o_key_length,
   output logic [31:0]       o_key_data
);

   localparam logic [SLOT_W:0] MAX_SLOT  = (SLOT_W+1)'(NUM_KEYS);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_KEYS-1);
   localparam logic [3:0] TOP_WORD = 4'(KEY_WORDS-1);

   ks_state_t         state_q, state_d;
   logic [31:0]       keyid_q [NUM_KEYS];
   logic [31:0]       keyid_d [NUM_KEYS];
   logic [NUM_KEYS-1:0] len_q, len_d, valid_q, valid_d;
   logic [SLOT_W-1:0] cur_q, cur_d, scan_q, scan_d, slot_q, slot_d;
   logic [31:0]       lk_keyid_q, lk_keyid_d, cur_keyid_q, cur_keyid_d;
   logic              cur_valid_q, cur_valid_d;
   logic              busy_q, busy_d, done_q, done_d, hit_q, hit_d;
   logic              wr_error_q, wr_error_d;
   logic [3:0]        word_q, word_d;
   logic              kvalid_q, kvalid_d, klen_q, klen_d;

   logic              wr_any, wr_ok;
   logic [31:0]       rd_data;

   assign wr_any = i_wr_key_we | i_wr_keyid_we | i_wr_valid_set |
                   i_wr_valid_clr | i_cur_we;
   // Writes are only taken when idle/done and the slot exists.
   assign wr_ok  = !busy_q && ({1'b0, i_wr_slot} < MAX_SLOT);

   nts_keystore_mem #(
      .NUM_KEYS (NUM_KEYS),
      .SLOT_W   (SLOT_W)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (wr_ok && i_wr_key_we),
      .i_waddr ({i_wr_slot, i_wr_word}),
      .i_wdata (i_wr_data),
      .i_raddr ({slot_q, word_q}),
      .o_rdata (rd_data)
   );

   always_comb begin
      keyid_d    = keyid_q;
      len_d      = len_q;
      valid_d    = valid_q;
      cur_d      = cur_q;
      wr_error_d = wr_any && !wr_ok;

      for (int i = 0; i < NUM_KEYS; i++) begin
         if (wr_ok && (i_wr_slot == SLOT_W'(i))) begin
            if (i_wr_keyid_we) begin
               keyid_d[i] = i_wr_data;
               len_d[i]   = i_wr_length;
            end
            if (i_wr_valid_clr) begin
               valid_d[i] = 1'b0;
            end else if (i_wr_valid_set) begin
               valid_d[i] = 1'b1;
            end
         end
      end
      if (wr_ok && i_cur_we) begin
         cur_d = i_wr_slot;
      end

      // Built from next-state storage so the outputs follow a write by one cycle.
      cur_keyid_d = keyid_d[cur_d];
      cur_valid_d = valid_d[cur_d];

      state_d    = state_q;
      scan_d     = scan_q;
      lk_keyid_d = lk_keyid_q;
      hit_d      = hit_q;
      slot_d     = slot_q;
      word_d     = word_q;

      case (state_q)
         ST_IDLE: begin
            if (i_lookup_start) begin
               state_d    = ST_SCAN;
               scan_d     = '0;
               lk_keyid_d = i_lookup_keyid;
               hit_d      = 1'b0;
               slot_d     = '0;
            end else if (i_current_start) begin
               hit_d  = 1'b0;
               // A same-cycle write to the current slot is honoured here.
               if (valid_d[cur_d]) begin
                  state_d = ST_STREAM;
                  slot_d  = cur_d;
                  word_d  = TOP_WORD;
               end else begin
                  state_d = ST_DONE;
                  slot_d  = '0;
               end
            end
         end
         ST_SCAN: begin
            if (valid_q[scan_q] && (keyid_q[scan_q] == lk_keyid_q)) begin
               state_d = ST_STREAM;
               slot_d  = scan_q;
               word_d  = TOP_WORD;
            end else if (scan_q == LAST_SLOT) begin
               state_d = ST_DONE;
            end else begin
               scan_d = scan_q + SLOT_W'(1);
            end
         end
         ST_STREAM: begin
            if (word_q == 4'd0) begin
               state_d = ST_DONE;
               hit_d   = 1'b1;
            end else begin
               word_d = word_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d   = (state_d == ST_SCAN) || (state_d == ST_STREAM);
      done_d   = (state_d == ST_DONE);
      kvalid_d = (state_d == ST_STREAM);
      klen_d   = (state_d == ST_STREAM) ? len_d[slot_d] : 1'b0;
   end

   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         state_q     <= ST_IDLE;
         keyid_q     <= '{default: '0};
         len_q       <= '0;
         valid_q     <= '0;
         cur_q       <= '0;
         scan_q      <= '0;
         slot_q      <= '0;
         lk_keyid_q  <= '0;
         cur_keyid_q <= '0;
         cur_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         hit_q       <= 1'b0;
         wr_error_q  <= 1'b0;
         word_q      <= '0;
         kvalid_q    <= 1'b0;
         klen_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         keyid_q     <= keyid_d;
         len_q       <= len_d;
         valid_q     <= valid_d;
         cur_q       <= cur_d;
         scan_q      <= scan_d;
         slot_q      <= slot_d;
         lk_keyid_q  <= lk_keyid_d;
         cur_keyid_q <= cur_keyid_d;
         cur_valid_q <= cur_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         hit_q       <= hit_d;
         wr_error_q  <= wr_error_d;
         word_q      <= word_d;
         kvalid_q    <= kvalid_d;
         klen_q      <= klen_d;
      end
   end

   assign o_wr_error      = wr_error_q;
   assign o_busy          = busy_q;
   assign o_done          = done_q;
   assign o_hit           = hit_q;
   assign o_slot          = slot_q;
   assign o_current_keyid = cur_keyid_q;
   assign o_current_valid = cur_valid_q;
   assign o_key_word      = word_q;
   assign o_key_valid     = kvalid_q;
   assign o_key_length    = klen_q;
   // RAM is read at the registered {slot, word}, so data aligns with o_key_word.
   assign o_key_data      = kvalid_q ? rd_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_nts_cookie_keystore.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_nts_cookie_keystore                                       |
// | Purpose   : Directed self-checking bench for nts_cookie_keystore.        |
// |             A second instance (NUM_KEYS=5) exercises out-of-range slots. |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_nts_cookie_keystore;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  wr_slot = '0;
   logic [3:0]  wr_word = '0;
   logic [31:0] wr_data = '0;
   logic        wr_key_we = 0, wr_keyid_we = 0, wr_length = 0;
   logic        wr_valid_set = 0, wr_valid_clr = 0, cur_we = 0;
   logic        lookup_start = 0, current_start = 0;
   logic [31:0] lookup_keyid = '0;
   logic        wr_error, busy, done, hit, cur_valid, key_valid, key_length;
   logic [1:0]  slot;
   logic [31:0] cur_keyid, key_data;
   logic [3:0]  key_word;

   nts_cookie_keystore #(.NUM_KEYS(4), .SLOT_W(2)) dut (
      .i_clk(clk), .i_areset(rst),
      .i_wr_slot(wr_slot), .i_wr_word(wr_word), .i_wr_data(wr_data),
      .i_wr_key_we(wr_key_we), .i_wr_keyid_we(wr_keyid_we),
      .i_wr_length(wr_length), .i_wr_valid_set(wr_valid_set),
      .i_wr_valid_clr(wr_valid_clr), .i_cur_we(cur_we),
      .o_wr_error(wr_error),
      .i_lookup_start(lookup_start), .i_lookup_keyid(lookup_keyid),
      .i_current_start(current_start),
      .o_busy(busy), .o_done(done), .o_hit(hit), .o_slot(slot),
      .o_current_keyid(cur_keyid), .o_current_valid(cur_valid),
      .o_key_word(key_word), .o_key_valid(key_valid),
      .o_key_length(key_length), .o_key_data(key_data)
   );

   // Five-slot instance: 3-bit slot index so slots 5..7 are out of range.
   logic [2:0]  b_wr_slot = '0;
   logic        b_key_we = 0, b_valid_set = 0;
   logic        b_wr_error, b_busy, b_done, b_hit, b_cur_valid;
   logic        b_key_valid, b_key_length;
   logic [2:0]  b_slot;
   logic [31:0] b_cur_keyid, b_key_data;
   logic [3:0]  b_key_word;

   nts_cookie_keystore #(.NUM_KEYS(5), .SLOT_W(3)) dut_b (
      .i_clk(clk), .i_areset(rst),
      .i_wr_slot(b_wr_slot), .i_wr_word(4'd0), .i_wr_data(32'h0),
      .i_wr_key_we(b_key_we), .i_wr_keyid_we(1'b0),
      .i_wr_length(1'b0), .i_wr_valid_set(b_valid_set),
      .i_wr_valid_clr(1'b0), .i_cur_we(1'b0),
      .o_wr_error(b_wr_error),
      .i_lookup_start(1'b0), .i_lookup_keyid(32'h0),
      .i_current_start(1'b0),
      .o_busy(b_busy), .o_done(b_done), .o_hit(b_hit), .o_slot(b_slot),
      .o_current_keyid(b_cur_keyid), .o_current_valid(b_cur_valid),
      .o_key_word(b_key_word), .o_key_valid(b_key_valid),
      .o_key_length(b_key_length), .o_key_data(b_key_data)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] key256 [8];
   logic [3:0]  cap_word [16];
   logic [31:0] cap_data [16];
   logic        cap_len [16];
   int          done_cyc, nwords;

   // One-cycle write pulse; called #1 after a rising edge.
   task automatic wr(input logic [1:0] s, input logic [3:0] w, input logic [31:0] d,
                     input logic kwe, input logic kidwe, input logic len,
                     input logic vs, input logic vc, input logic cw);
      wr_slot = s; wr_word = w; wr_data = d; wr_key_we = kwe; wr_keyid_we = kidwe;
      wr_length = len; wr_valid_set = vs; wr_valid_clr = vc; cur_we = cw;
      @(posedge clk); #1;
      wr_key_we = 0; wr_keyid_we = 0; wr_valid_set = 0; wr_valid_clr = 0; cur_we = 0;
   endtask

   // Issues a start and records the key stream and the cycle of o_done
   // (cycle 0 = start cycle). done_cyc = -1 if the operation never completes.
   task automatic run_op(input logic is_lookup, input logic [31:0] id);
      done_cyc = -1;
      nwords   = 0;
      lookup_keyid  = id;
      lookup_start  = is_lookup;
      current_start = !is_lookup;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         lookup_start  = 0;
         current_start = 0;
         if (key_valid) begin
            if (nwords < 16) begin
               cap_word[nwords] = key_word;
               cap_data[nwords] = key_data;
               cap_len[nwords]  = key_length;
            end
            nwords++;
         end
         if (done) begin
            done_cyc = n;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({wr_error, busy, done, hit, slot, cur_keyid, cur_valid,
           key_word, key_valid, key_length, key_data} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b hit=%b kv=%b curv=%b curid=%h want all 0",
                  busy, done, hit, key_valid, cur_valid, cur_keyid);
      end
      rst = 0;
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done, key_valid, cur_valid} !== 4'b0) begin
         n_bad++;
         $display("FAIL post_reset_idle: got busy=%b done=%b kv=%b curv=%b want 0",
                  busy, done, key_valid, cur_valid);
      end
   endtask

   task automatic test_key_load_hit;
      logic [31:0] exp;
      for (int w = 0; w < 16; w++)
         wr(2'd2, 4'(w), (w >= 8) ? key256[w-8] : 32'h0, 1, 0, 0, 0, 0, 0);
      wr(2'd2, 4'd0, 32'h6c47f0d3, 0, 1, 0, 0, 0, 0);
      wr(2'd2, 4'd0, 32'h0, 0, 0, 0, 1, 0, 0);
      run_op(1, 32'h6c47f0d3);
      n_cmp++;
      if (done_cyc !== 20) begin
         n_bad++; $display("FAIL hit_latency: got %0d want 20", done_cyc);
      end
      n_cmp++;
      if (hit !== 1'b1 || slot !== 2'd2) begin
         n_bad++; $display("FAIL hit_result: got hit=%b slot=%0d want hit=1 slot=2", hit, slot);
      end
      n_cmp++;
      if (nwords !== 16) begin
         n_bad++; $display("FAIL hit_word_count: got %0d want 16", nwords);
      end
      for (int j = 0; j < 16; j++) begin
         exp = (15 - j >= 8) ? key256[15-j-8] : 32'h0;
         n_cmp++;
         if (cap_word[j] !== 4'(15 - j) || cap_data[j] !== exp || cap_len[j] !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_stream[%0d]: got word=%0d data=%h len=%b want word=%0d data=%h len=0",
                     j, cap_word[j], cap_data[j], cap_len[j], 15 - j, exp);
         end
      end
   endtask

   task automatic test_miss;
      run_op(1, 32'h12345678);
      n_cmp++;
      if (done_cyc !== 5 || hit !== 1'b0 || nwords !== 0) begin
         n_bad++;
         $display("FAIL miss: got done_cyc=%0d hit=%b words=%0d want 5/0/0", done_cyc, hit, nwords);
      end
   endtask

   task automatic test_duplicates;
      wr(2'd1, 4'd0, 32'haabbccdd, 0, 1, 1, 1, 0, 0);
      wr(2'd3, 4'd0, 32'haabbccdd, 0, 1, 1, 1, 0, 0);
      run_op(1, 32'haabbccdd);
      n_cmp++;
      if (done_cyc !== 19 || hit !== 1'b1 || slot !== 2'd1 || cap_len[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL dup_lowest: got done=%0d hit=%b slot=%0d len=%b want 19/1/1/1",
                  done_cyc, hit, slot, cap_len[0]);
      end
      wr(2'd1, 4'd0, 32'h0, 0, 0, 0, 0, 1, 0);
      run_op(1, 32'haabbccdd);
      n_cmp++;
      if (done_cyc !== 21 || hit !== 1'b1 || slot !== 2'd3) begin
         n_bad++;
         $display("FAIL dup_after_clear: got done=%0d hit=%b slot=%0d want 21/1/3", done_cyc, hit, slot);
      end
      wr(2'd1, 4'd0, 32'h0, 0, 0, 0, 1, 1, 0);
      run_op(1, 32'haabbccdd);
      n_cmp++;
      if (slot !== 2'd3 || hit !== 1'b1) begin
         n_bad++;
         $display("FAIL set_clr_together: got slot=%0d hit=%b want 3/1", slot, hit);
      end
      // Slot 0 holds key ID 0 from reset but is invalid: must miss.
      run_op(1, 32'h0);
      n_cmp++;
      if (done_cyc !== 5 || hit !== 1'b0) begin
         n_bad++; $display("FAIL id0_invalid: got done=%0d hit=%b want 5/0", done_cyc, hit);
      end
      wr(2'd0, 4'd0, 32'h0, 0, 1, 0, 1, 0, 0);
      run_op(1, 32'h0);
      n_cmp++;
      if (done_cyc !== 18 || hit !== 1'b1 || slot !== 2'd0) begin
         n_bad++;
         $display("FAIL id0_valid: got done=%0d hit=%b slot=%0d want 18/1/0", done_cyc, hit, slot);
      end
      wr(2'd0, 4'd0, 32'h0, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_write_busy;
      lookup_keyid = 32'h6c47f0d3;
      lookup_start = 1;
      repeat (5) begin
         @(posedge clk); #1;
         lookup_start = 0;
      end
      wr_slot = 2'd2; wr_word = 4'd15; wr_data = 32'hdeadbeef; wr_key_we = 1;
      @(posedge clk); #1;
      wr_key_we = 0;
      n_cmp++;
      if (wr_error !== 1'b1) begin
         n_bad++; $display("FAIL busy_wr_error: got %b want 1", wr_error);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (wr_error !== 1'b0) begin
         n_bad++; $display("FAIL busy_wr_error_pulse: got %b want 0", wr_error);
      end
      for (int n = 0; n < 40 && !done; n++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      run_op(1, 32'h6c47f0d3);
      n_cmp++;
      if (cap_data[0] !== 32'hd16aeda8 || hit !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_data_kept: got word15=%h hit=%b want d16aeda8/1", cap_data[0], hit);
      end
      // Out-of-range slot on the five-slot instance.
      b_wr_slot = 3'd5; b_key_we = 1;
      @(posedge clk); #1;
      b_key_we = 0;
      n_cmp++;
      if (b_wr_error !== 1'b1) begin
         n_bad++; $display("FAIL slot5_error: got %b want 1", b_wr_error);
      end
      b_wr_slot = 3'd4; b_valid_set = 1;
      @(posedge clk); #1;
      b_valid_set = 0;
      n_cmp++;
      if (b_wr_error !== 1'b0) begin
         n_bad++; $display("FAIL slot4_accepted: got %b want 0", b_wr_error);
      end
      b_wr_slot = 3'd7; b_valid_set = 1;
      @(posedge clk); #1;
      b_valid_set = 0;
      n_cmp++;
      if (b_wr_error !== 1'b1 || b_busy !== 1'b0) begin
         n_bad++; $display("FAIL slot7_error: got err=%b busy=%b want 1/0", b_wr_error, b_busy);
      end
   endtask

   task automatic test_current;
      wr(2'd2, 4'd0, 32'h0, 0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (cur_keyid !== 32'h6c47f0d3 || cur_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL current_select: got id=%h valid=%b want 6c47f0d3/1", cur_keyid, cur_valid);
      end
      run_op(0, 32'h0);
      n_cmp++;
      if (done_cyc !== 17 || hit !== 1'b1 || slot !== 2'd2 || nwords !== 16 ||
          cap_data[0] !== 32'hd16aeda8 || cap_word[15] !== 4'd0) begin
         n_bad++;
         $display("FAIL current_stream: got done=%0d hit=%b slot=%0d words=%0d w15=%h want 17/1/2/16/d16aeda8",
                  done_cyc, hit, slot, nwords, cap_data[0]);
      end
      wr(2'd2, 4'd0, 32'h0, 0, 0, 0, 0, 1, 0);
      n_cmp++;
      if (cur_valid !== 1'b0) begin
         n_bad++; $display("FAIL current_valid_clear: got %b want 0", cur_valid);
      end
      run_op(0, 32'h0);
      n_cmp++;
      if (done_cyc !== 1 || hit !== 1'b0 || nwords !== 0) begin
         n_bad++;
         $display("FAIL current_invalid: got done=%0d hit=%b words=%0d want 1/0/0", done_cyc, hit, nwords);
      end
      wr(2'd2, 4'd0, 32'h0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic test_reset_mid_stream;
      bit seen = 0;
      lookup_keyid = 32'h6c47f0d3;
      lookup_start = 1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         lookup_start = 0;
         if (key_valid && key_word == 4'd9) begin
            seen = 1;
            break;
         end
      end
      n_cmp++;
      if (!seen) begin
         n_bad++; $display("FAIL reach_word9: got timeout want word 9");
      end
      rst = 1;
      #1;
      n_cmp++;
      if (key_valid !== 1'b0 || busy !== 1'b0 || cur_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid: got kv=%b busy=%b curv=%b want 0/0/0", key_valid, busy, cur_valid);
      end
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      run_op(1, 32'h6c47f0d3);
      n_cmp++;
      if (done_cyc !== 5 || hit !== 1'b0) begin
         n_bad++; $display("FAIL after_reset_miss: got done=%0d hit=%b want 5/0", done_cyc, hit);
      end
   endtask

   initial begin
      key256 = '{32'h3fc91575, 32'h8a2b4c6d, 32'h0e1f2a3b, 32'h4c5d6e7f,
                 32'h90a1b2c3, 32'hd4e5f607, 32'h18293a4b, 32'hd16aeda8};
      test_reset();
      test_key_load_hit();
      test_miss();
      test_duplicates();
      test_write_busy();
      test_current();
      test_reset_mid_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
